// File: rtl/fifo_flops_th.sv
// fifo_flops_th: flop-based synchronous FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Simultaneous push and pop are accepted in one cycle (also when full).
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   -> first-word-fall-through: Dout shows the head word
//                combinationally while pndng=1, 0 when empty
//   undefined -> Dout registered, valid the cycle after an accepted pop
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   Din          write data, captured on an accepted push
//   push / pop   write / read requests
//   Dout         read data
//   pndng        FIFO not empty
//   full         count == DEPTH
//   count        current occupancy
//   almost_full  count >= AF_TH
//   almost_empty count <= AE_TH
//   overflow     sticky: push while full without a concurrent accepted pop
//   underflow    sticky: pop while empty
module fifo_flops_th #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BITS  = 16,
  parameter int unsigned AF_TH = DEPTH - 2,
  parameter int unsigned AE_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BITS-1:0]              Din,
  input  logic                         push,
  input  logic                         pop,
  output logic [BITS-1:0]              Dout,
  output logic                         pndng,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_pndng;
  logic            w_full;
  logic            w_push_ok;
  logic            w_pop_ok;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;

  // Status decodes of the registered occupancy
  always_comb begin
    w_pndng      = (r_count != '0);
    w_full       = (r_count == CW'(DEPTH));
    pndng        = w_pndng;
    full         = w_full;
    count        = r_count;
    almost_full  = (32'(r_count) >= AF_TH);
    almost_empty = (32'(r_count) <= AE_TH);
    overflow     = r_overflow;
    underflow    = r_underflow;
  end

  // Accept rules; a pop frees the slot a push into a full FIFO needs
  always_comb begin
    w_pop_ok     = pop & w_pndng;
    w_push_ok    = push & (~w_full | w_pop_ok);
    w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  end

  // Storage array, intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= Din;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (push & w_full & ~w_pop_ok) begin
        r_overflow <= 1'b1;
      end
      if (pop & ~w_pndng) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through while the FIFO holds data
  always_comb begin
    Dout = w_pndng ? r_mem[r_rd_ptr] : '0;
  end
`else
  logic [BITS-1:0] r_dout;

  // Read data captured on the accepting edge, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_pop_ok) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    Dout = r_dout;
  end
`endif

endmodule

// File: tb/tb_fifo_flops_th.sv
// Testbench for fifo_flops_th (DEPTH=16, BITS=16, AF_TH=14, AE_TH=2).
// Directed vector table followed by queue-model sequences for fill/drain,
// wrap-around streaming, full/empty push+pop and mid-stream reset.
module tb_fifo_flops_th;

  logic        clk;
  logic        rst;
  logic [15:0] Din;
  logic        push;
  logic        pop;
  logic [15:0] Dout;
  logic        pndng;
  logic        full;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [15:0] q[$];
  logic        m_ovf;
  logic        m_udf;
  logic [15:0] m_dout;

  fifo_flops_th #(
    .DEPTH(16),
    .BITS (16),
    .AF_TH(14),
    .AE_TH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Din         (Din),
    .push        (push),
    .pop         (pop),
    .Dout        (Dout),
    .pndng       (pndng),
    .full        (full),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic        push;
    logic        pop;
    logic [15:0] din;
    int          cnt;
    logic [15:0] d_reg;
    logic [15:0] d_fwft;
    logic        pnd;
    logic        ful;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive inputs at negedge, sample #1 after the following posedge
  task automatic apply(input logic r, input logic pu, input logic po, input logic [15:0] d);
    @(negedge clk);
    rst  = r;
    push = pu;
    pop  = po;
    Din  = d;
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle, advance the queue model and compare every output
  task automatic step(input string nm, input logic r, input logic pu, input logic po,
                      input logic [15:0] d);
    int          cnt;
    logic        pop_ok;
    logic        push_ok;
    logic [15:0] exp_dout;
    cnt     = q.size();
    pop_ok  = po && (cnt > 0);
    push_ok = pu && ((cnt < 16) || pop_ok);
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      if (pu && !push_ok) m_ovf = 1'b1;
      if (po && cnt == 0) m_udf = 1'b1;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
    end
`ifdef FIFO_FWFT_EN
    exp_dout = (q.size() > 0) ? q[0] : 16'h0;
`else
    exp_dout = m_dout;
`endif
    apply(r, pu, po, d);
    check({nm, ".count"}, 32'(count), 32'(q.size()));
    check({nm, ".dout"}, 32'(Dout), 32'(exp_dout));
    check({nm, ".pndng"}, 32'(pndng), 32'(q.size() != 0));
    check({nm, ".full"}, 32'(full), 32'(q.size() == 16));
    check({nm, ".af"}, 32'(almost_full), 32'(q.size() >= 14));
    check({nm, ".ae"}, 32'(almost_empty), 32'(q.size() <= 2));
    check({nm, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({nm, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  initial begin
    logic [15:0] exp_d;
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    Din  = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;

    //          name        rst push pop din      cnt d_reg    d_fwft   pnd ful af ae ovf udf
    vecs[0]  = '{"rst",       1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{"push1",     0, 1, 0, 16'h1111, 1, 16'h0000, 16'h1111, 1, 0, 0, 1, 0, 0};
    vecs[2]  = '{"push2",     0, 1, 0, 16'h2222, 2, 16'h0000, 16'h1111, 1, 0, 0, 1, 0, 0};
    vecs[3]  = '{"push3",     0, 1, 0, 16'h3333, 3, 16'h0000, 16'h1111, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{"pop1",      0, 0, 1, 16'h0000, 2, 16'h1111, 16'h2222, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{"pushpop",   0, 1, 1, 16'h4444, 2, 16'h2222, 16'h3333, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{"pop2",      0, 0, 1, 16'h0000, 1, 16'h3333, 16'h4444, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{"pop3",      0, 0, 1, 16'h0000, 0, 16'h4444, 16'h0000, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{"pop_empty", 0, 0, 1, 16'h0000, 0, 16'h4444, 16'h0000, 0, 0, 0, 1, 0, 1};
    vecs[9]  = '{"pp_empty",  0, 1, 1, 16'h5555, 1, 16'h4444, 16'h5555, 1, 0, 0, 1, 0, 1};
    vecs[10] = '{"pop4",      0, 0, 1, 16'h0000, 0, 16'h5555, 16'h0000, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{"rst_prio",  1, 1, 1, 16'h7777, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
`ifdef FIFO_FWFT_EN
      exp_d = vecs[i].d_fwft;
`else
      exp_d = vecs[i].d_reg;
`endif
      check({vecs[i].nm, ".count"}, 32'(count), 32'(vecs[i].cnt));
      check({vecs[i].nm, ".dout"}, 32'(Dout), 32'(exp_d));
      check({vecs[i].nm, ".pndng"}, 32'(pndng), 32'(vecs[i].pnd));
      check({vecs[i].nm, ".full"}, 32'(full), 32'(vecs[i].ful));
      check({vecs[i].nm, ".af"}, 32'(almost_full), 32'(vecs[i].af));
      check({vecs[i].nm, ".ae"}, 32'(almost_empty), 32'(vecs[i].ae));
      check({vecs[i].nm, ".ovf"}, 32'(overflow), 32'(vecs[i].ovf));
      check({vecs[i].nm, ".udf"}, 32'(underflow), 32'(vecs[i].udf));
    end

    // Fill to full, overflow attempt, drain in order, underflow attempt
    step("fill_rst", 1, 0, 0, 16'h0);
    for (int i = 0; i < 16; i++) step("fill", 0, 1, 0, 16'(i));
    check("full_count", 32'(count), 32'd16);
    step("ovf_push", 0, 1, 0, 16'hDEAD);
    for (int i = 0; i < 16; i++) step("drain", 0, 0, 1, 16'h0);
    step("udf_pop", 0, 0, 1, 16'h0);

    // Streaming at count=8 long enough to wrap the pointers twice
    step("strm_rst", 1, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) step("strm_fill", 0, 1, 0, 16'(16'h100 + i));
    for (int i = 0; i < 40; i++) step("strm", 0, 1, 1, 16'(16'h200 + i));

    // Push+pop while full: both accepted, no overflow
    step("pf_rst", 1, 0, 0, 16'h0);
    for (int i = 0; i < 16; i++) step("pf_fill", 0, 1, 0, 16'(16'h300 + i));
    step("pf_pushpop", 0, 1, 1, 16'h0BEE);
    check("pf_no_ovf", 32'(overflow), 32'd0);

    // Push+pop while empty: push lands, underflow sets, word readable
    step("pe_rst", 1, 0, 0, 16'h0);
    step("pe_pushpop", 0, 1, 1, 16'hC0DE);
    check("pe_count", 32'(count), 32'd1);
    step("pe_pop", 0, 0, 1, 16'h0);

    // Reset mid-stream at count=10, then first word after reset comes out
    for (int i = 0; i < 10; i++) step("mr_fill", 0, 1, 0, 16'(16'h400 + i));
    step("mr_rst", 1, 0, 0, 16'h0);
    step("mr_push", 0, 1, 0, 16'hABCD);
    step("mr_pop", 0, 0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
    check("mr_dout_abcd", 32'(Dout), 32'h0000ABCD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
